// File: rtl/shiftuni_param.sv
// Parametrised universal shift register with multi-step shift/rotate ops,
// executed one bit per clock behind a start/busy/done handshake.
module shiftuni_param #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] amt,
    input  logic [WIDTH-1:0] din,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    typedef enum logic [2:0] {
        M_HOLD = 3'b000,
        M_SHR  = 3'b001,
        M_SHL  = 3'b010,
        M_LOAD = 3'b011,
        M_ROR  = 3'b100,
        M_ROL  = 3'b101,
        M_ASR  = 3'b110,
        M_RSVD = 3'b111
    } mode_t;

    state_t             r_state;
    mode_t              r_mode;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_q;
    logic               r_busy;
    logic               r_done;

    state_t             w_state_nx;
    mode_t              w_mode_nx;
    mode_t              w_mode_in;
    logic [CNT_W-1:0]   w_cnt_nx;
    logic [WIDTH-1:0]   w_q_nx;
    logic               w_busy_nx;
    logic               w_done_nx;
    logic [WIDTH-1:0]   w_step;
    logic               w_is_shift;

    assign w_mode_in = mode_t'(mode);

    // One 1-bit step of the latched operation; serial inputs are sampled live.
    always_comb begin
        w_step = r_q;
        case (r_mode)
            M_SHR:   w_step = {sin_l, r_q[WIDTH-1:1]};
            M_SHL:   w_step = {r_q[WIDTH-2:0], sin_r};
            M_ROR:   w_step = {r_q[0], r_q[WIDTH-1:1]};
            M_ROL:   w_step = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
            M_ASR:   w_step = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
            default: w_step = r_q;
        endcase
    end

    always_comb begin
        w_is_shift = 1'b0;
        case (w_mode_in)
            M_SHR, M_SHL, M_ROR, M_ROL, M_ASR: w_is_shift = 1'b1;
            default:                           w_is_shift = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nx = r_state;
        w_mode_nx  = r_mode;
        w_cnt_nx   = r_cnt;
        w_q_nx     = r_q;
        w_busy_nx  = r_busy;
        w_done_nx  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_mode_in == M_LOAD) begin
                        w_q_nx    = din;
                        w_done_nx = 1'b1;
                    end else if (w_is_shift && (amt != '0)) begin
                        w_mode_nx  = w_mode_in;
                        w_cnt_nx   = amt;
                        w_busy_nx  = 1'b1;
                        w_state_nx = S_RUN;
                    end else begin
                        w_done_nx = 1'b1;
                    end
                end
            end
            S_RUN: begin
                w_q_nx   = w_step;
                w_cnt_nx = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nx = S_IDLE;
                    w_busy_nx  = 1'b0;
                    w_done_nx  = 1'b1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_busy_nx  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_mode  <= M_HOLD;
            r_cnt   <= '0;
            r_q     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_mode  <= w_mode_nx;
            r_cnt   <= w_cnt_nx;
            r_q     <= w_q_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
        end
    end

    assign q      = r_q;
    assign sout_l = r_q[WIDTH-1];
    assign sout_r = r_q[0];
    assign busy   = r_busy;
    assign done   = r_done;

endmodule
